banco_lector_secuencial: RTL and testbench

- Read-side sequencer for the 8x16-bit register bank (Banco8Registros16Bit).
- On a start command it walks a contiguous, wrapping range of bank registers.
- It uses both bank read ports, DireccionA and DireccionB, so two registers are fetched per access.
- Fetched words are streamed out one at a time on a valid/ready handshake. It is the reading counterpart to the bank's write port.

---
 rtl/banco_lector_secuencial_pkg.sv | 16 +
 rtl/banco_lector_secuencial_if.sv | 32 +++
 rtl/banco_lector_secuencial_buffer2.sv | 42 ++++
 rtl/banco_lector_secuencial.sv | 120 ++++++++++++
 tb/tb_banco_lector_secuencial.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/banco_lector_secuencial_pkg.sv
// Shared definitions for the register-bank read sequencer and the 8x16 bank.
package banco_pkg;

   localparam int ANCHO_DEF     = 16;
   localparam int ANCHO_DIR_DEF = 3;
   localparam int NUM_REGISTROS = 8;

   // Sequencer state encoding, also exported on the debug state port.
   typedef enum logic [1:0] {
      EST_REPOSO   = 2'd0,
      EST_LEER     = 2'd1,
      EST_ENTREGAR = 2'd2,
      EST_FIN      = 2'd3
   } estado_t;

endpackage

// File: rtl/banco_lector_secuencial_if.sv
// Bank read ports plus the outgoing word stream.
//
// Handshake: the sequencer (master) drives Dato/Ultimo with Valido.
// A word moves on any rising clock edge where Valido && Listo are both 1.
// While Valido is 1 and Listo is 0, Dato and Ultimo stay stable and Valido stays high.
// Valido never depends on Listo.
// RtaA/RtaB are combinational bank reads of DireccionA/DireccionB.
interface banco_lector_secuencial_if
   import banco_pkg::*;
#(
   parameter int ANCHO     = ANCHO_DEF,
   parameter int ANCHO_DIR = ANCHO_DIR_DEF
);
   logic [ANCHO_DIR-1:0] DireccionA;
   logic [ANCHO_DIR-1:0] DireccionB;
   logic [ANCHO-1:0]     RtaA;
   logic [ANCHO-1:0]     RtaB;
   logic [ANCHO-1:0]     Dato;
   logic                 Valido;
   logic                 Listo;
   logic                 Ultimo;

   modport master (
      output DireccionA, DireccionB, Dato, Valido, Ultimo,
      input  RtaA, RtaB, Listo
   );

   modport slave (
      input  DireccionA, DireccionB, Dato, Valido, Ultimo,
      output RtaA, RtaB, Listo
   );
endinterface

// File: rtl/banco_lector_secuencial_buffer2.sv
// Two-word capture register for one bank read pair, with a word index
// selecting which captured word is presented.
module banco_lector_buffer2 #(
   parameter int ANCHO = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cargar_i,   // capture both read ports, restart at word 0
   input  logic             avanzar_i,  // move on to the second captured word
   input  logic [ANCHO-1:0] rta_a_i,
   input  logic [ANCHO-1:0] rta_b_i,
   output logic [ANCHO-1:0] dato_o,
   output logic             idx_o
);

   logic [ANCHO-1:0] palabra0_q;
   logic [ANCHO-1:0] palabra1_q;
   logic             idx_q;

   // Capture the pair on load; the index only ever steps from 0 to 1.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         palabra0_q <= '0;
         palabra1_q <= '0;
         idx_q      <= 1'b0;
      end else if (cargar_i) begin
         palabra0_q <= rta_a_i;
         palabra1_q <= rta_b_i;
         idx_q      <= 1'b0;
      end else if (avanzar_i) begin
         idx_q      <= 1'b1;
      end
   end

   // Output mux: both inputs are registers, so Dato stays glitch-free.
   always_comb begin
      dato_o = idx_q ? palabra1_q : palabra0_q;
   end

   assign idx_o = idx_q;

endmodule

// File: rtl/banco_lector_secuencial.sv
// Read-side sequencer for the 8x16 register bank.
// It walks a wrapping address range two registers at a time,
// using both bank read ports.
// The fetched words are streamed out one per handshake.
module banco_lector_secuencial
   import banco_pkg::*;
#(
   parameter int ANCHO     = ANCHO_DEF,
   parameter int ANCHO_DIR = ANCHO_DIR_DEF
) (
   input  logic                 Reloj,
   input  logic                 Reiniciar,
   input  logic                 Iniciar,
   input  logic [ANCHO_DIR-1:0] DireccionInicio,
   input  logic [ANCHO_DIR:0]   Cantidad,
   output logic                 Ocupado,
   output logic                 Terminado,
   output estado_t              Estado,
   banco_lector_secuencial_if.master bus
);

   // Largest burst is the whole bank; anything above saturates to it.
   localparam logic [ANCHO_DIR:0]   MAX_CANT = {1'b1, {ANCHO_DIR{1'b0}}};
   localparam logic [ANCHO_DIR:0]   ULTIMA   = (ANCHO_DIR+1)'(1);
   localparam logic [ANCHO_DIR-1:0] UNO      = ANCHO_DIR'(1);
   localparam logic [ANCHO_DIR-1:0] DOS      = ANCHO_DIR'(2);

   estado_t              estado_q;
   logic [ANCHO_DIR-1:0] dir_a_q;
   logic [ANCHO_DIR-1:0] dir_b_q;
   logic [ANCHO_DIR:0]   restante_q;
   logic                 valido_q;

   logic                 transferencia;
   logic                 cargar;
   logic                 avanzar;
   logic                 idx;
   logic [ANCHO-1:0]     dato;

   // Strobes into the capture buffer, all derived from registered state.
   always_comb begin
      transferencia = valido_q && bus.Listo;
      cargar        = (estado_q == EST_LEER);
      avanzar       = (estado_q == EST_ENTREGAR) && transferencia &&
                      (restante_q != ULTIMA) && !idx;
   end

   banco_lector_buffer2 #(.ANCHO(ANCHO)) u_buffer (
      .clk_i     (Reloj),
      .rst_ni    (Reiniciar),
      .cargar_i  (cargar),
      .avanzar_i (avanzar),
      .rta_a_i   (bus.RtaA),
      .rta_b_i   (bus.RtaB),
      .dato_o    (dato),
      .idx_o     (idx)
   );

   // Main FSM: it owns the addresses, the remaining count and Valido.
   // The bank is read combinationally, so the capture happens in the LEER cycle,
   // after the addresses settle.
   always_ff @(posedge Reloj or negedge Reiniciar) begin
      if (!Reiniciar) begin
         estado_q   <= EST_REPOSO;
         dir_a_q    <= '0;
         dir_b_q    <= '0;
         restante_q <= '0;
         valido_q   <= 1'b0;
      end else begin
         case (estado_q)
            EST_REPOSO: begin
               if (Iniciar && (Cantidad != '0)) begin
                  dir_a_q    <= DireccionInicio;
                  dir_b_q    <= DireccionInicio + UNO;
                  restante_q <= (Cantidad > MAX_CANT) ? MAX_CANT : Cantidad;
                  estado_q   <= EST_LEER;
               end
            end
            EST_LEER: begin
               valido_q <= 1'b1;
               estado_q <= EST_ENTREGAR;
            end
            EST_ENTREGAR: begin
               if (transferencia) begin
                  restante_q <= restante_q - ULTIMA;
                  if (restante_q == ULTIMA) begin
                     valido_q <= 1'b0;
                     estado_q <= EST_FIN;
                  end else if (idx) begin
                     // Pair exhausted: the next pair is two registers further on and wraps.
                     dir_a_q  <= dir_a_q + DOS;
                     dir_b_q  <= dir_b_q + DOS;
                     valido_q <= 1'b0;
                     estado_q <= EST_LEER;
                  end
               end
            end
            EST_FIN: begin
               estado_q <= EST_REPOSO;
            end
            default: begin
               estado_q <= EST_REPOSO;
            end
         endcase
      end
   end

   // Outputs decoded from registers only.
   always_comb begin
      bus.DireccionA = dir_a_q;
      bus.DireccionB = dir_b_q;
      bus.Dato       = dato;
      bus.Valido     = valido_q;
      bus.Ultimo     = valido_q && (restante_q == ULTIMA);
      Ocupado        = (estado_q != EST_REPOSO);
      Terminado      = (estado_q == EST_FIN);
      Estado         = estado_q;
   end

endmodule

// File: tb/tb_banco_lector_secuencial.sv
// Directed bench for the bank read sequencer.
// It models the register bank as a preloaded array.
module tb_banco_lector_secuencial;

   localparam int LIMITE = 60;

   logic        Reloj;
   logic        Reiniciar;
   logic        Iniciar;
   logic [2:0]  DireccionInicio;
   logic [3:0]  Cantidad;
   logic        Ocupado;
   logic        Terminado;
   logic [1:0]  estado;

   logic [15:0] mem [8];
   logic [15:0] exp_q[$];

   int checks   = 0;
   int failures = 0;

   banco_lector_secuencial_if #(.ANCHO(16), .ANCHO_DIR(3)) bus ();

   banco_lector_secuencial dut (
      .Reloj           (Reloj),
      .Reiniciar       (Reiniciar),
      .Iniciar         (Iniciar),
      .DireccionInicio (DireccionInicio),
      .Cantidad        (Cantidad),
      .Ocupado         (Ocupado),
      .Terminado       (Terminado),
      .Estado          (estado),
      .bus             (bus)
   );

   // Bank model: combinational reads.
   assign bus.RtaA = mem[bus.DireccionA];
   assign bus.RtaB = mem[bus.DireccionB];

   // Clock and watchdog.
   initial begin
      Reloj = 1'b0;
      forever #5 Reloj = ~Reloj;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Reloj);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic iniciar(input logic [2:0] dir, input logic [3:0] cant);
      DireccionInicio = dir;
      Cantidad        = cant;
      Iniciar         = 1'b1;
      tick();
      Iniciar         = 1'b0;
   endtask

   // Consume a burst: optional stall on one word, optional stray Iniciar.
   task automatic recolectar(input int stall_word, input int stall_len, input int pulse_cyc,
                             output int n_words, output int n_term, output int lat);
      int stall_cnt;
      bit fin;
      bit detener;
      n_words   = 0;
      n_term    = 0;
      lat       = -1;
      stall_cnt = 0;
      fin       = 1'b0;
      for (int cyc = 0; cyc < LIMITE && !fin; cyc++) begin
         Iniciar = (cyc == pulse_cyc);
         if (Terminado) n_term++;
         if (!Ocupado) begin
            fin = 1'b1;
         end else begin
            if (bus.Valido && lat < 0) lat = cyc + 1;
            detener = (n_words == stall_word) && (stall_cnt < stall_len) &&
                      (bus.Valido || stall_cnt > 0);
            if (detener) begin
               if (stall_cnt > 0) begin
                  check("valido_retenido", bus.Valido, 1);
                  check("dato_retenido", bus.Dato, exp_q[0]);
               end
               bus.Listo = 1'b0;
               stall_cnt++;
            end else begin
               bus.Listo = 1'b1;
            end
            if (bus.Valido && bus.Listo) begin
               check("hay_esperado", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  check("dato", bus.Dato, exp_q[0]);
                  check("ultimo", bus.Ultimo, exp_q.size() == 1);
                  void'(exp_q.pop_front());
               end
               n_words++;
            end else if (!bus.Valido) begin
               check("ultimo_sin_valido", bus.Ultimo, 0);
            end
            tick();
         end
      end
      Iniciar   = 1'b0;
      bus.Listo = 1'b1;
      check("fin_en_plazo", fin, 1);
   endtask

   initial begin
      int n, t, lat;
      for (int i = 0; i < 8; i++) mem[i] = 16'h0010 + 16'(i);
      Reiniciar       = 1'b1;
      Iniciar         = 1'b0;
      DireccionInicio = '0;
      Cantidad        = '0;
      bus.Listo       = 1'b1;
      #2 Reiniciar = 1'b0;
      #1;
      check("rst_valido", bus.Valido, 0);
      check("rst_dato", bus.Dato, 0);
      check("rst_dir_a", bus.DireccionA, 0);
      check("rst_dir_b", bus.DireccionB, 0);
      check("rst_ocupado", Ocupado, 0);
      check("rst_terminado", Terminado, 0);
      check("rst_estado", estado, 0);
      tick();
      Reiniciar = 1'b1;
      tick();

      // 1: start 2, four words
      exp_q = '{16'h0012, 16'h0013, 16'h0014, 16'h0015};
      iniciar(3'd2, 4'd4);
      check("t1_leer_valido", bus.Valido, 0);
      check("t1_ocupado", Ocupado, 1);
      check("t1_dir_a", bus.DireccionA, 2);
      check("t1_dir_b", bus.DireccionB, 3);
      recolectar(-1, 0, -1, n, t, lat);
      check("t1_latencia", lat, 2);
      check("t1_palabras", n, 4);
      check("t1_terminado", t, 1);
      check("t1_dir_a_final", bus.DireccionA, 4);

      // 2: wrap from 6
      exp_q = '{16'h0016, 16'h0017, 16'h0010, 16'h0011};
      iniciar(3'd6, 4'd4);
      check("t2_dir_a", bus.DireccionA, 6);
      check("t2_dir_b", bus.DireccionB, 7);
      recolectar(-1, 0, -1, n, t, lat);
      check("t2_palabras", n, 4);
      check("t2_terminado", t, 1);
      check("t2_dir_a_final", bus.DireccionA, 0);
      check("t2_dir_b_final", bus.DireccionB, 1);

      // 3: odd count
      exp_q = '{16'h0010, 16'h0011, 16'h0012};
      iniciar(3'd0, 4'd3);
      recolectar(-1, 0, -1, n, t, lat);
      check("t3_palabras", n, 3);
      check("t3_terminado", t, 1);
      check("t3_sin_valido", bus.Valido, 0);

      // 4: stall the second word for three cycles
      exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014};
      iniciar(3'd0, 4'd5);
      recolectar(1, 3, -1, n, t, lat);
      check("t4_palabras", n, 5);
      check("t4_terminado", t, 1);

      // 5a: zero count is ignored
      iniciar(3'd1, 4'd0);
      check("t5_cero_ocupado", Ocupado, 0);
      tick();
      check("t5_cero_ocupado2", Ocupado, 0);
      check("t5_cero_estado", estado, 0);

      // 5b: count 12 saturates to 8; stray Iniciar mid-burst
      exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013,
                16'h0014, 16'h0015, 16'h0016, 16'h0017};
      iniciar(3'd0, 4'd12);
      DireccionInicio = 3'd5;
      Cantidad        = 4'd2;
      recolectar(-1, 0, 5, n, t, lat);
      check("t5_palabras", n, 8);
      check("t5_terminado", t, 1);
      tick();
      check("t5_sin_reinicio", Ocupado, 0);

      // 6: asynchronous reset during ENTREGAR
      iniciar(3'd4, 4'd4);
      tick();
      check("t6_entregando", bus.Valido, 1);
      #2 Reiniciar = 1'b0;
      #1;
      check("t6_valido", bus.Valido, 0);
      check("t6_dato", bus.Dato, 0);
      check("t6_dir_a", bus.DireccionA, 0);
      check("t6_dir_b", bus.DireccionB, 0);
      check("t6_ultimo", bus.Ultimo, 0);
      check("t6_ocupado", Ocupado, 0);
      check("t6_terminado", Terminado, 0);
      check("t6_estado", estado, 0);
      tick();
      check("t6_sin_terminado", Terminado, 0);
      Reiniciar = 1'b1;
      tick();
      check("t6_sin_terminado2", Terminado, 0);
      exp_q = '{16'h0013, 16'h0014};
      iniciar(3'd3, 4'd2);
      recolectar(-1, 0, -1, n, t, lat);
      check("t6_palabras", n, 2);
      check("t6_terminado_nuevo", t, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
